// File: rtl/mem_access_unit.sv
// Multi-cycle sequencer between the CPU core and a single-ported byte-addressable memory.
// Arbitrates fetch against load/store, extends sub-word loads and performs SB/SH as read-modify-write.
module mem_access_unit #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [ADDR_SIZE-1:0] if_addr,
    output logic                 if_ready,
    output logic [WORD_SIZE-1:0] if_instr,
    output logic                 if_err,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [2:0]           d_funct3,
    input  logic [ADDR_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ready,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_err,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_write_en,
    output logic [WORD_SIZE-1:0] mem_write_data,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_RMW_RD,
        S_STORE
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [WORD_SIZE-1:0] wbuf_q, wbuf_d;
    logic                 err_pend_q, err_pend_d;
    logic                 err_port_q, err_port_d;   // 1 = data port, 0 = fetch port
    logic                 if_ready_q, if_ready_d;
    logic [WORD_SIZE-1:0] if_instr_q, if_instr_d;
    logic                 if_err_q, if_err_d;
    logic                 d_ready_q, d_ready_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 d_err_q, d_err_d;

    logic                 accept;
    logic                 d_illegal;
    logic                 d_misaligned;
    logic                 d_bad;
    logic [WORD_SIZE-1:0] lane_shift;
    logic [WORD_SIZE-1:0] load_ext;
    logic [WORD_SIZE-1:0] merged;

    // Both ready flags must be low so a request still held during its ready pulse is not served twice.
    assign accept = (state_q == S_IDLE) && !if_ready_q && !d_ready_q && !err_pend_q;

    assign d_illegal    = (d_funct3 == 3'b011) || (d_funct3[2:1] == 2'b11) || (d_we && d_funct3[2]);
    assign d_misaligned = ((d_funct3[1:0] == 2'b01) && d_addr[0]) ||
                          ((d_funct3[1:0] == 2'b10) && (d_addr[1:0] != 2'b00));
    assign d_bad        = d_illegal || d_misaligned;

    assign lane_shift = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = mem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_shift[7]}}, lane_shift[7:0]};
            3'b001:  load_ext = {{16{lane_shift[15]}}, lane_shift[15:0]};
            3'b100:  load_ext = {24'd0, lane_shift[7:0]};
            3'b101:  load_ext = {16'd0, lane_shift[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // Byte-lane merge for SB/SH: the latched store data replaces the addressed lane(s) of the read word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            localparam int         HOFS = 8 * (gi % 2);
            logic byte_hit;
            logic half_hit;
            assign byte_hit = (funct3_q[1:0] == 2'b00) && (addr_q[1:0] == LANE);
            assign half_hit = (funct3_q[1:0] == 2'b01) && (addr_q[1] == LANE[1]);
            assign merged[8*gi +: 8] = byte_hit ? wbuf_q[7:0] :
                                       half_hit ? wbuf_q[HOFS +: 8] :
                                                  mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        wbuf_d     = wbuf_q;
        err_pend_d = err_pend_q;
        err_port_d = err_port_q;
        if_ready_d = 1'b0;
        if_instr_d = if_instr_q;
        if_err_d   = if_err_q;
        d_ready_d  = 1'b0;
        d_rdata_d  = d_rdata_q;
        d_err_d    = d_err_q;

        case (state_q)
            S_IDLE: begin
                if (err_pend_q) begin
                    err_pend_d = 1'b0;
                    if (err_port_q) begin
                        d_ready_d = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        if_ready_d = 1'b1;
                        if_err_d   = 1'b1;
                        if_instr_d = '0;
                    end
                end else if (accept && d_req) begin
                    addr_d   = d_addr;
                    funct3_d = d_funct3;
                    wbuf_d   = d_wdata;
                    if (d_bad) begin
                        err_pend_d = 1'b1;
                        err_port_d = 1'b1;
                    end else if (!d_we) begin
                        state_d = S_LOAD;
                    end else if (d_funct3[1:0] == 2'b10) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end else if (accept && if_req) begin
                    addr_d = if_addr;
                    if (if_addr[1:0] != 2'b00) begin
                        err_pend_d = 1'b1;
                        err_port_d = 1'b0;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if_instr_d = mem_rdata;
                if_err_d   = 1'b0;
                if_ready_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_LOAD: begin
                d_rdata_d = load_ext;
                d_err_d   = 1'b0;
                d_ready_d = 1'b1;
                state_d   = S_IDLE;
            end
            S_RMW_RD: begin
                wbuf_d  = merged;
                state_d = S_STORE;
            end
            S_STORE: begin
                d_rdata_d = '0;
                d_err_d   = 1'b0;
                d_ready_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            funct3_q   <= '0;
            wbuf_q     <= '0;
            err_pend_q <= 1'b0;
            err_port_q <= 1'b0;
            if_ready_q <= 1'b0;
            if_instr_q <= '0;
            if_err_q   <= 1'b0;
            d_ready_q  <= 1'b0;
            d_rdata_q  <= '0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            wbuf_q     <= wbuf_d;
            err_pend_q <= err_pend_d;
            err_port_q <= err_port_d;
            if_ready_q <= if_ready_d;
            if_instr_q <= if_instr_d;
            if_err_q   <= if_err_d;
            d_ready_q  <= d_ready_d;
            d_rdata_q  <= d_rdata_d;
            d_err_q    <= d_err_d;
        end
    end

    // The memory sees the word-aligned address only while an access is in flight.
    assign mem_addr       = ((state_q != S_IDLE) && !rst) ? {addr_q[ADDR_SIZE-1:2], 2'b00} : '0;
    assign mem_write_en   = (state_q == S_STORE) && !rst;
    assign mem_write_data = (state_q == S_STORE) ? wbuf_q : '0;

    assign if_ready = if_ready_q;
    assign if_instr = if_instr_q;
    assign if_err   = if_err_q;
    assign d_ready  = d_ready_q;
    assign d_rdata  = d_rdata_q;
    assign d_err    = d_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: drivers push expected completions and memory writes,
// a negedge monitor pops and compares whenever the DUT reports a completion or a write.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_instr;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_rdata;

    logic [7:0]  mem [256];

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    exp_t if_q[$];
    exp_t d_q[$];
    wr_t  wr_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    mem_access_unit #(.WORD_SIZE(32), .ADDR_SIZE(32)) dut (
        .clk(clk),
        .rst(rst),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_ready(if_ready),
        .if_instr(if_instr),
        .if_err(if_err),
        .d_req(d_req),
        .d_we(d_we),
        .d_funct3(d_funct3),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_ready(d_ready),
        .d_rdata(d_rdata),
        .d_err(d_err),
        .mem_addr(mem_addr),
        .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = {mem[8'(mem_addr[7:0] + 8'd3)], mem[8'(mem_addr[7:0] + 8'd2)],
                        mem[8'(mem_addr[7:0] + 8'd1)], mem[mem_addr[7:0]]};

    // Little-endian byte memory with synchronous word write.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h93; mem[1] = 8'h80; mem[2] = 8'h50; mem[3] = 8'h01;
        mem[4] = 8'h13;
        forever begin
            @(posedge clk);
            if (mem_write_en) begin
                mem[mem_write_data[7:0] === 8'hxx ? 0 : mem_addr[7:0]]                 <= mem_write_data[7:0];
                mem[8'(mem_addr[7:0] + 8'd1)] <= mem_write_data[15:8];
                mem[8'(mem_addr[7:0] + 8'd2)] <= mem_write_data[23:16];
                mem[8'(mem_addr[7:0] + 8'd3)] <= mem_write_data[31:24];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares every completion and every memory write against the scoreboard.
    initial begin
        exp_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (if_ready === 1'b1) begin
                $display("[cyc %0d] fetch done instr=%h err=%b", cyc, if_instr, if_err);
                if (if_q.size() == 0) begin
                    chk("unexpected if_ready", 32'd1, 32'd0);
                end else begin
                    e = if_q.pop_front();
                    chk("if_instr", if_instr, e.data);
                    chk("if_err", 32'(if_err), 32'(e.err));
                    chk("if_latency", 32'(cyc - e.cyc), 32'(e.lat));
                end
            end
            if (d_ready === 1'b1) begin
                $display("[cyc %0d] data done rdata=%h err=%b", cyc, d_rdata, d_err);
                if (d_q.size() == 0) begin
                    chk("unexpected d_ready", 32'd1, 32'd0);
                end else begin
                    e = d_q.pop_front();
                    chk("d_rdata", d_rdata, e.data);
                    chk("d_err", 32'(d_err), 32'(e.err));
                    chk("d_latency", 32'(cyc - e.cyc), 32'(e.lat));
                end
            end
            if (mem_write_en === 1'b1) begin
                $display("[cyc %0d] mem write addr=%h data=%h", cyc, mem_addr, mem_write_data);
                if (wr_q.size() == 0) begin
                    chk("unexpected mem_write_en", 32'd1, 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    chk("mem_addr on write", mem_addr, w.addr);
                    chk("mem_write_data", mem_write_data, w.data);
                end
            end
        end
    end

    task automatic d_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_data,
                            input logic exp_err, input int lat);
        exp_t e;
        bit   seen;
        @(negedge clk);
        e.data = exp_data; e.err = exp_err; e.cyc = cyc; e.lat = lat;
        d_q.push_back(e);
        d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (d_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("d_ready timeout", 32'd0, 32'd1);
        d_req = 1'b0;
    endtask

    task automatic if_access(input logic [31:0] addr, input logic [31:0] exp_data,
                             input logic exp_err, input int lat);
        exp_t e;
        bit   seen;
        @(negedge clk);
        e.data = exp_data; e.err = exp_err; e.cyc = cyc; e.lat = lat;
        if_q.push_back(e);
        if_addr = addr; if_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("if_ready timeout", 32'd0, 32'd1);
        if_req = 1'b0;
    endtask

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr; w.data = data;
        wr_q.push_back(w);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, " ready/err flags"}, {28'd0, if_ready, if_err, d_ready, d_err}, 32'd0);
        chk({tag, " if_instr"}, if_instr, 32'd0);
        chk({tag, " d_rdata"}, d_rdata, 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " mem_write_en"}, 32'(mem_write_en), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_funct3 = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        // Fetch of the preloaded instruction.
        if_access(32'd0, 32'h01508093, 1'b0, 2);

        // SW then LW round trip.
        expect_write(32'd24, 32'h00000015);
        d_access(1'b1, 3'b010, 32'd24, 32'h00000015, 32'd0, 1'b0, 2);
        d_access(1'b0, 3'b010, 32'd24, 32'd0, 32'h00000015, 1'b0, 2);

        // SB read-modify-write and sub-word loads.
        expect_write(32'd24, 32'h11223344);
        d_access(1'b1, 3'b010, 32'd24, 32'h11223344, 32'd0, 1'b0, 2);
        expect_write(32'd24, 32'h1122AB44);
        d_access(1'b1, 3'b000, 32'd25, 32'h000000AB, 32'd0, 1'b0, 3);
        d_access(1'b0, 3'b000, 32'd25, 32'd0, 32'hFFFFFFAB, 1'b0, 2);
        d_access(1'b0, 3'b100, 32'd25, 32'd0, 32'h000000AB, 1'b0, 2);
        d_access(1'b0, 3'b001, 32'd26, 32'd0, 32'h00001122, 1'b0, 2);

        // SH into the low half, then halfword/byte loads on both halves.
        expect_write(32'd32, 32'hAABBCCDD);
        d_access(1'b1, 3'b010, 32'd32, 32'hAABBCCDD, 32'd0, 1'b0, 2);
        expect_write(32'd32, 32'hAABBBEEF);
        d_access(1'b1, 3'b001, 32'd32, 32'h1234BEEF, 32'd0, 1'b0, 3);
        d_access(1'b0, 3'b001, 32'd32, 32'd0, 32'hFFFFBEEF, 1'b0, 2);
        d_access(1'b0, 3'b101, 32'd34, 32'd0, 32'h0000AABB, 1'b0, 2);
        d_access(1'b0, 3'b000, 32'd35, 32'd0, 32'hFFFFFFAA, 1'b0, 2);
        d_access(1'b0, 3'b010, 32'd32, 32'd0, 32'hAABBBEEF, 1'b0, 2);

        // Error cases: no write expected, data forced to 0.
        d_access(1'b0, 3'b001, 32'd27, 32'd0, 32'd0, 1'b1, 2);
        d_access(1'b1, 3'b010, 32'd26, 32'h0BADF00D, 32'd0, 1'b1, 2);
        d_access(1'b0, 3'b011, 32'd24, 32'd0, 32'd0, 1'b1, 2);
        d_access(1'b1, 3'b100, 32'd24, 32'h0BADF00D, 32'd0, 1'b1, 2);
        if_access(32'd2, 32'd0, 1'b1, 2);

        // Simultaneous requests: data port wins, fetch follows.
        fork
            d_access(1'b0, 3'b010, 32'd24, 32'd0, 32'h1122AB44, 1'b0, 2);
            if_access(32'd4, 32'h00000013, 1'b0, 5);
        join

        // Reset during RMW_RD of an SH: aborted, no write.
        @(negedge clk);
        d_we = 1'b1; d_funct3 = 3'b001; d_addr = 32'd26; d_wdata = 32'h0000BEEF; d_req = 1'b1;
        @(negedge clk);
        chk("rmw read address", mem_addr, 32'd24);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        check_cleared("mid-op reset");
        rst = 1'b0;
        d_access(1'b0, 3'b010, 32'd24, 32'd0, 32'h1122AB44, 1'b0, 2);

        repeat (4) @(negedge clk);
        chk("pending fetch completions", 32'(if_q.size()), 32'd0);
        chk("pending data completions", 32'(d_q.size()), 32'd0);
        chk("pending memory writes", 32'(wr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
